frame_streamer: RTL and testbench

//  Producer end of the complex-sample handshake consumed by arg_max: holds one frame of

---
 rtl/frame_streamer.sv | 139 +++++++++++++
 tb/tb_frame_streamer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// Frame replay source: stores one frame of I/Q samples and plays it out over a valid/ready handshake.
// Optional FRAME_STREAMER_REPEAT_EN: loop the stored frame continuously until reset.
module frame_streamer #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [index_bits-1:0] wr_addr,
  input  logic [i_bits-1:0]     wr_xi,
  input  logic [q_bits-1:0]     wr_xq,
  input  logic                  start,
  output logic                  busy,
  output logic                  s_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [i_bits-1:0]     xi,
  output logic [q_bits-1:0]     xq,
  output logic [index_bits-1:0] index,
  output logic                  tlast,
  output logic                  frame_done
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_STREAM = 1'b1;

  localparam logic [index_bits-1:0] LAST_INDEX = index_bits'(buffer_length - 1);
  localparam logic [index_bits:0]   LENGTH     = (index_bits + 1)'(buffer_length);

  logic [i_bits-1:0] mem_i [buffer_length];
  logic [q_bits-1:0] mem_q [buffer_length];

  logic [0:0]            state_reg, state_next;
  logic                  busy_reg, busy_next;
  logic                  valid_reg, valid_next;
  logic                  tlast_reg, tlast_next;
  logic                  frame_done_reg, frame_done_next;
  logic [index_bits-1:0] index_reg, index_next;
  logic [i_bits-1:0]     xi_reg;
  logic [q_bits-1:0]     xq_reg;

  logic                  transfer;
  logic                  wr_ok;
  logic                  load;
  logic [index_bits-1:0] read_addr;
  logic [index_bits-1:0] index_inc;

  assign transfer  = valid_reg & m_axis_tready;
  assign index_inc = index_reg + 1'b1;
  // Writes are only safe when no frame is being read out.
  assign wr_ok     = wr_en & (state_reg == STATE_IDLE) & ~start & ({1'b0, wr_addr} < LENGTH);

  always_comb begin
    state_next      = state_reg;
    busy_next       = busy_reg;
    valid_next      = valid_reg;
    tlast_next      = tlast_reg;
    index_next      = index_reg;
    frame_done_next = 1'b0;
    load            = 1'b0;
    read_addr       = '0;
    case (state_reg)
      STATE_IDLE: begin
        if (start) begin
          state_next = STATE_STREAM;
          busy_next  = 1'b1;
          valid_next = 1'b1;
          tlast_next = 1'b0;
          index_next = '0;
          load       = 1'b1;
        end
      end
      default: begin
        if (transfer) begin
          if (tlast_reg) begin
            frame_done_next = 1'b1;
            index_next      = '0;
            tlast_next      = 1'b0;
`ifdef FRAME_STREAMER_REPEAT_EN
            load            = 1'b1;
`else
            state_next      = STATE_IDLE;
            busy_next       = 1'b0;
            valid_next      = 1'b0;
`endif
          end else begin
            index_next = index_inc;
            read_addr  = index_inc;
            load       = 1'b1;
            tlast_next = (index_inc == LAST_INDEX);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= STATE_IDLE;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      tlast_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      index_reg      <= '0;
      xi_reg         <= '0;
      xq_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      valid_reg      <= valid_next;
      tlast_reg      <= tlast_next;
      frame_done_reg <= frame_done_next;
      index_reg      <= index_next;
      // Sample registers only move on a load, so they hold through stalls and after the frame.
      if (load) begin
        xi_reg <= mem_i[read_addr];
        xq_reg <= mem_q[read_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_i[wr_addr] <= wr_xi;
      mem_q[wr_addr] <= wr_xq;
    end
  end

  assign busy          = busy_reg;
  assign s_axis_tvalid = valid_reg;
  assign tlast         = tlast_reg;
  assign frame_done    = frame_done_reg;
  assign index         = index_reg;
  assign xi            = xi_reg;
  assign xq            = xq_reg;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: the stimulus side pushes expected frames,
// a negedge monitor pops and compares on every handshake transfer.
module tb_frame_streamer;
  localparam int LEN = 10;
  localparam int IB  = 4;
  localparam int DW  = 12;

  typedef struct {
    int xi;
    int xq;
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, wr_en, start, ready;
  logic [IB-1:0] wr_addr;
  logic signed [DW-1:0] wr_xi, wr_xq;
  logic busy, valid, tlast, frame_done;
  logic signed [DW-1:0] xi, xq;
  logic [IB-1:0] index;

  int   model_i [LEN];
  int   model_q [LEN];
  bit   model_busy;
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  frame_streamer #(.buffer_length(LEN), .index_bits(IB), .i_bits(DW), .q_bits(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_xi(wr_xi), .wr_xq(wr_xq),
    .start(start), .busy(busy), .s_axis_tvalid(valid), .m_axis_tready(ready),
    .xi(xi), .xq(xq), .index(index), .tlast(tlast), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void push_frame();
    for (int k = 0; k < LEN; k++) sb.push_back('{model_i[k], model_q[k], k, (k == LEN - 1)});
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model decides acceptance from the frame-level rules.
  task automatic drive_cycle(input bit do_wr, input int addr, input int d_i, input int d_q,
                             input bit do_st);
    logic signed [DW-1:0] ti, tq;
    ti = DW'(d_i);
    tq = DW'(d_q);
    wr_en   = do_wr;
    wr_addr = IB'(addr);
    wr_xi   = ti;
    wr_xq   = tq;
    start   = do_st;
    if (do_wr && !model_busy && !do_st && addr < LEN) begin
      model_i[addr] = int'(ti);
      model_q[addr] = int'(tq);
    end
    if (do_st && !model_busy) begin
      push_frame();
      model_busy = 1'b1;
    end
    $display("drive wr=%0b addr=%0d xi=%0d xq=%0d start=%0b", do_wr, addr, ti, tq, do_st);
    cycle();
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain(input int mode, output int cyc);
    cyc = 0;
    while ((model_busy || sb.size() != 0) && cyc < 300) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 2);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      cyc++;
    end
    chk("drain_bound", int'(cyc < 300), 1);
  endtask

  // Monitor: compares every transfer against the scoreboard, plus hold and frame_done rules.
  initial begin
    bit   fd_exp = 1'b0;
    bit   stalled = 1'b0;
    int   h_xi = 0, h_xq = 0, h_idx = 0, h_last = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        fd_exp  = 1'b0;
        stalled = 1'b0;
        continue;
      end
      chk("frame_done", int'(frame_done), int'(fd_exp));
      if (stalled) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_xi", int'(xi), h_xi);
        chk("hold_xq", int'(xq), h_xq);
        chk("hold_index", int'(index), h_idx);
        chk("hold_tlast", int'(tlast), h_last);
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_transfer: got index %0d expected no transfer", index);
          fd_exp = 1'b0;
        end else begin
          e = sb.pop_front();
          $display("xfer index=%0d xi=%0d xq=%0d tlast=%0b (exp %0d %0d %0d %0b)",
                   index, xi, xq, tlast, e.idx, e.xi, e.xq, e.last);
          chk("xfer_xi", int'(xi), e.xi);
          chk("xfer_xq", int'(xq), e.xq);
          chk("xfer_index", int'(index), e.idx);
          chk("xfer_tlast", int'(tlast), int'(e.last));
          fd_exp = e.last;
          if (e.last) begin
`ifdef FRAME_STREAMER_REPEAT_EN
            push_frame();
`else
            model_busy = 1'b0;
`endif
          end
        end
      end else begin
        fd_exp = 1'b0;
      end
      stalled = valid && !ready;
      h_xi = int'(xi); h_xq = int'(xq); h_idx = int'(index); h_last = int'(tlast);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fd_count;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; ready = 1'b0;
    wr_addr = '0; wr_xi = '0; wr_xq = '0;
    model_busy = 1'b0;
    repeat (3) cycle();
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_tlast", int'(tlast), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_index", int'(index), 0);
    chk("reset_xi", int'(xi), 0);
    chk("reset_xq", int'(xq), 0);
    rst = 1'b0;
    cycle();

    for (int k = 0; k < LEN; k++) drive_cycle(1'b1, k, k + 1, -(k + 1), 1'b0);

`ifdef FRAME_STREAMER_REPEAT_EN
    ready = 1'b1;
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    fd_count = 0;
    for (int i = 0; i < 25; i++) begin
      chk("repeat_valid", int'(valid), 1);
      chk("repeat_busy", int'(busy), 1);
      cycle();
      fd_count += int'(frame_done);
    end
    chk("repeat_frame_done_count", fd_count, 2);
    rst = 1'b1;
    sb.delete();
    model_busy = 1'b0;
    cycle();
    rst = 1'b0;
    chk("repeat_rst_valid", int'(valid), 0);
    cycle();
`else
    // Back-to-back frame with tready held high.
    ready = 1'b1;
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    chk("t1_first_valid", int'(valid), 1);
    chk("t1_first_busy", int'(busy), 1);
    chk("t1_first_index", int'(index), 0);
    drain(0, cyc);
    chk("t1_cycles", cyc, LEN);
    chk("t1_done_pulse", int'(frame_done), 1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_valid_after", int'(valid), 0);
    cycle();
    chk("t1_done_one_cycle", int'(frame_done), 0);

    // Stalled frame.
    ready = 1'b0;
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    drain(1, cyc);
    cycle();

    // Start and write while busy, out-of-range write while idle.
    ready = 1'b1;
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    repeat (4) cycle();
    chk("t3_index_at_start", int'(index), 4);
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    drive_cycle(1'b1, 2, 100, 100, 1'b0);
    drain(0, cyc);
    cycle();
    drive_cycle(1'b1, 12, 77, 77, 1'b0);
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    drain(0, cyc);
    cycle();

    // Reset mid-frame at index 6.
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    repeat (6) cycle();
    chk("t4_index_before_rst", int'(index), 6);
    rst = 1'b1;
    sb.delete();
    model_busy = 1'b0;
    cycle();
    rst = 1'b0;
    chk("t4_valid", int'(valid), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_index", int'(index), 0);
    chk("t4_frame_done", int'(frame_done), 0);
    cycle();
    chk("t4_no_done_after", int'(frame_done), 0);
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    chk("t4_replay_xi", int'(xi), 1);
    drain(0, cyc);
    cycle();

    // Extreme values.
    drive_cycle(1'b1, 0, -2048, 2047, 1'b0);
    drive_cycle(1'b1, 9, 2047, -2048, 1'b0);
    drive_cycle(1'b0, 0, 0, 0, 1'b1);
    drain(2, cyc);
    cycle();

    // Randomized writes, starts and backpressure.
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 1));
      drive_cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 15) == 0));
    end
    drain(2, cyc);
    cycle();
    chk("final_busy", int'(busy), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
